// File: rtl/sig_capture.sv
// sig_capture: buffers committed stores to SIG_ADDR in a first-word-fall-through
// FIFO and drains them over a valid/ready port. A store to HALT_ADDR stops
// capture. The FIFO then drains, and a sticky halt flag is raised.
module sig_capture #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] SIG_ADDR  = 32'h0000_0F00,
  parameter logic [31:0] HALT_ADDR = 32'hCAFE_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_valid,
  input  logic [31:0]               st_addr,
  input  logic [31:0]               st_data,
  output logic                      sig_valid,
  output logic [31:0]               sig_data,
  input  logic                      sig_ready,
  output logic                      halt,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               total
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   total_q, total_d;
  logic          overflow_q, overflow_d;

  logic full_s, empty_s, cap_s, pop_s, push_s, drop_s;

  // Decode capture / pop / push / drop from registered occupancy and the store bus.
  always_comb begin
    full_s  = (level_q == FULL_LVL);
    empty_s = (level_q == {LW{1'b0}});
    cap_s   = st_valid && (st_addr == SIG_ADDR) && (state_q == ST_RUN);
    pop_s   = !empty_s && sig_ready;
    push_s  = cap_s && (!full_s || pop_s);
    drop_s  = cap_s && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy, counters and the run/drain/done FSM.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Saturating count of accepted words.
    if (push_s && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end else begin
      total_d = total_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_RUN: begin
        if (st_valid && (st_addr == HALT_ADDR)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Empty-on-entry still spends one cycle here.
        if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      total_q    <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage. A push into a full FIFO with a concurrent pop overwrites
  // the slot being read out this cycle, which is safe because the head is
  // consumed at the same edge.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= st_data;
    end
  end

  // Outputs are driven only from registered state. sig_data reads as zero
  // while empty, so it is also zero after reset.
  always_comb begin
    sig_valid = !empty_s;
    if (!empty_s) begin
      sig_data = mem_q[rd_ptr_q];
    end else begin
      sig_data = 32'h0000_0000;
    end
    halt     = (state_q == ST_DONE);
    overflow = overflow_q;
    level    = level_q;
    total    = total_q;
  end

endmodule

// File: tb/tb_sig_capture.sv
// Self-checking bench for sig_capture: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_sig_capture;

  localparam int          DEPTH = 16;
  localparam logic [31:0] SIGA  = 32'h0000_0F00;
  localparam logic [31:0] HALTA = 32'hCAFE_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_ready;
  logic        halt;
  logic        overflow;
  logic [4:0]  level;
  logic [15:0] total;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue plus a phase number (0 run, 1 drain, 2 done).
  logic [31:0] mq[$];
  int          m_phase;
  int          m_total;
  bit          m_over;

  sig_capture #(.DEPTH(DEPTH), .SIG_ADDR(SIGA), .HALT_ADDR(HALTA)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .sig_valid(sig_valid), .sig_data(sig_data),
    .sig_ready(sig_ready), .halt(halt), .overflow(overflow),
    .level(level), .total(total)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic rd);
    int  n;
    bit  pop, cap;
    rst = r; st_valid = v; st_addr = a; st_data = d; sig_ready = rd;
    n = mq.size();
    if (!r) begin
      mq.delete(); m_phase = 0; m_total = 0; m_over = 0;
    end else begin
      pop = (n != 0) && rd;
      cap = v && (a == SIGA) && (m_phase == 0);
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (n < DEPTH || pop) begin
          mq.push_back(d);
          if (m_total < 65535) m_total++;
        end else begin
          m_over = 1;
        end
      end
      if (m_phase == 0 && v && a == HALTA) m_phase = 1;
      else if (m_phase == 1 && n == 0) m_phase = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 32'h0, 32'h0, rd);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rd);
    step(1'b1, 1'b1, a, d, rd);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, ($urandom_range(0, 1) == 0) ? SIGA : $urandom, $urandom, 1'(($urandom_range(0, 1))));
      outs = {sig_valid, sig_data, level, total, overflow, halt};
      n_checks++;
      if (outs !== 56'd0) $display("FAIL reset_hold: got %h want 0", outs); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      outs = {sig_valid, sig_data, level, total, overflow, halt};
      n_checks++;
      if (outs !== 56'd0) $display("FAIL reset_idle: got %h want 0", outs); else n_pass++;
    end
  endtask

  task automatic test_capture();
    do_reset();
    store(SIGA, 32'h11, 1'b1);
    n_checks++;
    if (!sig_valid || sig_data !== 32'h11) $display("FAIL cap_11: got v=%b d=%h want v=1 d=11", sig_valid, sig_data); else n_pass++;
    store(SIGA, 32'h22, 1'b1);
    n_checks++;
    if (!sig_valid || sig_data !== 32'h22) $display("FAIL cap_22: got v=%b d=%h want v=1 d=22", sig_valid, sig_data); else n_pass++;
    store(32'h0000_0104, 32'h99, 1'b1);
    n_checks++;
    if (sig_valid !== 1'b0) $display("FAIL cap_other_addr: got v=%b want v=0", sig_valid); else n_pass++;
    store(SIGA, 32'h33, 1'b1);
    n_checks++;
    if (!sig_valid || sig_data !== 32'h33) $display("FAIL cap_33: got v=%b d=%h want v=1 d=33", sig_valid, sig_data); else n_pass++;
    idle(1'b1);
    n_checks++;
    if (total !== 16'd3 || sig_valid !== 1'b0) $display("FAIL cap_total: got total=%0d v=%b want total=3 v=0", total, sig_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 17; i++) store(SIGA, 32'h100 + 32'(i), 1'b0);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || total !== 16'd16)
      $display("FAIL bp_full: got level=%0d ovf=%b total=%0d want 16 1 16", level, overflow, total);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (!sig_valid || sig_data !== 32'h100 + 32'(i))
        $display("FAIL bp_order_%0d: got v=%b d=%h want v=1 d=%h", i, sig_valid, sig_data, 32'h100 + 32'(i));
      else n_pass++;
      idle(1'b1);
    end
    n_checks++;
    if (level !== 5'd0 || sig_valid !== 1'b0) $display("FAIL bp_empty: got level=%0d v=%b want 0 0", level, sig_valid); else n_pass++;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) store(SIGA, 32'h200 + 32'(i), 1'b0);
    store(SIGA, 32'hAA, 1'b1);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b0 || total !== 16'd17)
      $display("FAIL fp_accept: got level=%0d ovf=%b total=%0d want 16 0 17", level, overflow, total);
    else n_pass++;
    for (int i = 1; i < 17; i++) begin
      n_checks++;
      if (!sig_valid || sig_data !== ((i == 16) ? 32'hAA : 32'h200 + 32'(i)))
        $display("FAIL fp_order_%0d: got v=%b d=%h want v=1 d=%h", i, sig_valid, sig_data,
                 (i == 16) ? 32'hAA : 32'h200 + 32'(i));
      else n_pass++;
      idle(1'b1);
    end
    n_checks++;
    if (sig_valid !== 1'b0) $display("FAIL fp_empty: got v=%b want 0", sig_valid); else n_pass++;
  endtask

  task automatic test_halt_drain();
    do_reset();
    for (int i = 0; i < 4; i++) store(SIGA, 32'h300 + 32'(i), 1'b0);
    store(HALTA, 32'hDEAD, 1'b0);
    store(SIGA, 32'h777, 1'b0);
    idle(1'b0);
    n_checks++;
    if (level !== 5'd4 || halt !== 1'b0 || total !== 16'd4)
      $display("FAIL hd_ignore: got level=%0d halt=%b total=%0d want 4 0 4", level, halt, total);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!sig_valid || sig_data !== 32'h300 + 32'(i))
        $display("FAIL hd_order_%0d: got v=%b d=%h want v=1 d=%h", i, sig_valid, sig_data, 32'h300 + 32'(i));
      else n_pass++;
      idle(1'b1);
    end
    n_checks++;
    if (halt !== 1'b0 || level !== 5'd0) $display("FAIL hd_early: got halt=%b level=%0d want 0 0", halt, level); else n_pass++;
    store(SIGA, 32'h888, 1'b1);
    n_checks++;
    if (halt !== 1'b1) $display("FAIL hd_halt: got halt=%b want 1", halt); else n_pass++;
    idle(1'b1);
    n_checks++;
    if (halt !== 1'b1 || level !== 5'd0 || total !== 16'd4)
      $display("FAIL hd_done: got halt=%b level=%0d total=%0d want 1 0 4", halt, level, total);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) store(SIGA, 32'h400 + 32'(i), 1'b0);
    store(HALTA, 32'h0, 1'b0);
    idle(1'b0);
    do_reset();
    n_checks++;
    if (level !== 5'd0 || halt !== 1'b0 || sig_valid !== 1'b0 || total !== 16'd0)
      $display("FAIL rmd_reset: got level=%0d halt=%b v=%b total=%0d want 0 0 0 0", level, halt, sig_valid, total);
    else n_pass++;
    store(SIGA, 32'h4242, 1'b0);
    n_checks++;
    if (!sig_valid || sig_data !== 32'h4242 || level !== 5'd1)
      $display("FAIL rmd_capture: got v=%b d=%h level=%0d want 1 4242 1", sig_valid, sig_data, level);
    else n_pass++;
  endtask

  task automatic test_random();
    int rdy_pct;
    int sel;
    logic [31:0] a;
    logic r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) rdy_pct = (c / 150) % 3 == 0 ? 10 : ((c / 150) % 3 == 1 ? 50 : 90);
      sel = $urandom_range(0, 99);
      a = (sel < 55) ? SIGA : ((sel < 57) ? HALTA : $urandom);
      r = !(m_phase == 2 ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0));
      step(r, 1'($urandom_range(0, 99) < 65), a, $urandom, 1'($urandom_range(0, 99) < rdy_pct));
      n_checks++;
      if (sig_valid !== (mq.size() != 0) || level !== 5'(mq.size()) || total !== 16'(m_total) ||
          overflow !== m_over || halt !== (m_phase == 2) ||
          (mq.size() != 0 && sig_data !== mq[0]))
        $display("FAIL rand_c%0d: got v=%b d=%h lvl=%0d tot=%0d ovf=%b halt=%b want v=%b d=%h lvl=%0d tot=%0d ovf=%b halt=%b",
                 c, sig_valid, sig_data, level, total, overflow, halt,
                 mq.size() != 0, (mq.size() != 0) ? mq[0] : 32'h0, mq.size(), m_total, m_over, m_phase == 2);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; sig_ready = 1'b0;
    mq.delete(); m_phase = 0; m_total = 0; m_over = 0;
    test_reset();
    test_capture();
    test_backpressure();
    test_full_pop();
    test_halt_drain();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
